// File: rtl/des_key_sequencer.sv
// Iterative DES key schedule: PC-1 on start, one PC-2 subkey per rk_valid/rk_ready handshake.
// Optional `DES_KS_ABORT_EN adds an abort input that drops an in-flight sequence without done.
module des_key_sequencer #(
    parameter int unsigned ROUND_IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [63:0]            key_in,
    input  logic                   decrypt,
    input  logic                   rk_ready,
`ifdef DES_KS_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   rk_valid,
    output logic [47:0]            round_key,
    output logic [ROUND_IDX_W-1:0] round_idx,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam int unsigned PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Table entries use DES numbering: bit 1 is the MSB of the vector.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int unsigned i = 0; i < 56; i++)
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int unsigned j = 0; j < 48; j++)
            r[6'(47 - j)] = cd[6'(56 - PC2_TAB[j])];
        return r;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state;
    logic [27:0] c, d;
    logic [3:0]  idx;
    logic        dir;

    logic [55:0] key_cd;
    logic [3:0]  idx_next;
    logic        two_step;
    logic        handshake;
    logic        unused_parity;

    assign key_cd    = pc1(key_in);
    assign idx_next  = idx + 4'd1;
    // Encrypt left-shifts and decrypt right-shifts coincide for positions 1..15.
    assign two_step  = !((idx_next == 4'd1) || (idx_next == 4'd8) || (idx_next == 4'd15));
    assign handshake = rk_valid && rk_ready;
    assign round_key = pc2({c, d});
    assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                             key_in[24], key_in[16], key_in[8],  key_in[0]};

    always_comb begin
        round_idx      = '0;
        round_idx[3:0] = idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            c        <= '0;
            d        <= '0;
            idx      <= '0;
            dir      <= 1'b0;
            rk_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dir      <= decrypt;
                        c        <= decrypt ? key_cd[55:28] : rotl(key_cd[55:28], 1'b0);
                        d        <= decrypt ? key_cd[27:0]  : rotl(key_cd[27:0], 1'b0);
                        idx      <= '0;
                        state    <= RUN;
                        rk_valid <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
`ifdef DES_KS_ABORT_EN
                    if (abort) begin
                        state    <= IDLE;
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                        idx      <= '0;
                    end else
`endif
                    if (handshake) begin
                        if (idx == 4'd15) begin
                            state    <= IDLE;
                            rk_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            idx <= idx_next;
                            c   <= dir ? rotr(c, two_step) : rotl(c, two_step);
                            d   <= dir ? rotr(d, two_step) : rotl(d, two_step);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_des_key_sequencer.sv
// Randomized self-checking bench for des_key_sequencer against a table-driven DES key schedule model.
module tb_des_key_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [63:0] key_in;
    logic        decrypt;
    logic        rk_ready;
`ifdef DES_KS_ABORT_EN
    logic        abort;
`endif
    logic        rk_valid;
    logic [47:0] round_key;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    logic [47:0] exp_keys [16];
    logic [47:0] obs      [16];
    logic [63:0] next_key;
    logic        next_dec;

    localparam logic [63:0] KNOWN = 64'h0123456789ABCDEF;

    int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_sequencer #(.ROUND_IDX_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .decrypt   (decrypt),
        .rk_ready  (rk_ready),
`ifdef DES_KS_ABORT_EN
        .abort     (abort),
`endif
        .rk_valid  (rk_valid),
        .round_key (round_key),
        .round_idx (round_idx),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key n is PC-2 of C0/D0 rotated left by the cumulative shift count; decrypt issues them reversed.
    task automatic compute_keys(input logic [63:0] k, input logic dec);
        bit          kb [64];
        bit          c0 [28];
        bit          d0 [28];
        bit          cd [56];
        logic [47:0] kk [16];
        int          s;
        s = 0;
        for (int i = 0; i < 64; i++) kb[i] = k[6'(63 - i)];
        for (int i = 0; i < 28; i++) begin
            c0[i] = kb[PC1_T[i] - 1];
            d0[i] = kb[PC1_T[i + 28] - 1];
        end
        for (int r = 0; r < 16; r++) begin
            s += SH[r];
            for (int j = 0; j < 28; j++) begin
                cd[j]      = c0[(j + s) % 28];
                cd[28 + j] = d0[(j + s) % 28];
            end
            kk[r] = '0;
            for (int j = 0; j < 48; j++) kk[r][6'(47 - j)] = cd[PC2_T[j] - 1];
        end
        for (int p = 0; p < 16; p++) exp_keys[p] = dec ? kk[15 - p] : kk[p];
    endtask

    task automatic issue_start(input logic [63:0] k, input logic dec);
        start   = 1'b1;
        key_in  = k;
        decrypt = dec;
        @(posedge clk);
        #1;
        start   = 1'b0;
        key_in  = {$urandom, $urandom};
        decrypt = 1'($urandom);
    endtask

    // mode: 0 ready always, 1 random ready, 2 stall at pos 4, 3 start inject at pos 6,
    // 4 async reset at pos 7, 5 abort at pos 9
    task automatic collect(input int mode, input bit chain, input string name);
        int p     = 0;
        int cyc   = 0;
        int stall = 0;
        bit rdy;
        bit injected = 0;
        while (p < 16 && cyc < 400) begin
            total++;
            if ({rk_valid, busy, done, round_idx, round_key} !== {1'b1, 1'b1, 1'b0, 4'(p), exp_keys[p]}) begin
                bad++;
                $display("FAIL %s pos%0d: got v=%b b=%b d=%b idx=%0d key=%h want v=1 b=1 d=0 idx=%0d key=%h",
                         name, p, rk_valid, busy, done, round_idx, round_key, p, exp_keys[p]);
            end
            obs[p] = round_key;
            rdy = 1'b1;
            if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
            if (mode == 2 && p == 4 && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end
            if (mode == 3 && p == 6 && !injected) begin
                start    = 1'b1;
                key_in   = '0;
                decrypt  = 1'b1;
                injected = 1'b1;
            end
            if (mode == 4 && p == 7) begin
                rk_ready = 1'b1;
                #2 rst = 1'b1;
                #1;
                total++;
                if ({rk_valid, busy, done, round_idx, round_key} !== '0) begin
                    bad++;
                    $display("FAIL %s async_rst: got v=%b b=%b d=%b idx=%0d key=%h want all zero",
                             name, rk_valid, busy, done, round_idx, round_key);
                end
                @(posedge clk);
                #1;
                total++;
                if ({rk_valid, busy, done, round_idx, round_key} !== '0) begin
                    bad++;
                    $display("FAIL %s rst_hold: got v=%b b=%b d=%b idx=%0d key=%h want all zero",
                             name, rk_valid, busy, done, round_idx, round_key);
                end
                rst = 1'b0;
                return;
            end
`ifdef DES_KS_ABORT_EN
            if (mode == 5 && p == 9) begin
                abort    = 1'b1;
                rk_ready = 1'b1;
                @(posedge clk);
                #1;
                abort = 1'b0;
                total++;
                if ({rk_valid, busy, done} !== 3'b000) begin
                    bad++;
                    $display("FAIL %s abort: got v=%b b=%b d=%b want 000", name, rk_valid, busy, done);
                end
                return;
            end
`endif
            rk_ready = rdy;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (rdy) p++;
            cyc++;
        end
        total++;
        if (p != 16) begin
            bad++;
            $display("FAIL %s timeout: got %0d keys want 16", name, p);
            return;
        end
        total++;
        if ({rk_valid, busy, done} !== 3'b001) begin
            bad++;
            $display("FAIL %s done_pulse: got v=%b b=%b d=%b want 001", name, rk_valid, busy, done);
        end
        if (mode == 0 || mode == 2) begin
            total++;
            if (cyc != (mode == 2 ? 19 : 16)) begin
                bad++;
                $display("FAIL %s cycles: got %0d want %0d", name, cyc, (mode == 2 ? 19 : 16));
            end
        end
        if (chain) begin
            start   = 1'b1;
            key_in  = next_key;
            decrypt = next_dec;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (!chain) begin
            total++;
            if ({rk_valid, busy, done} !== 3'b000) begin
                bad++;
                $display("FAIL %s after_done: got v=%b b=%b d=%b want 000", name, rk_valid, busy, done);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        decrypt = 1'b0;
        rk_ready = 1'b0;
`ifdef DES_KS_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rk_valid, busy, done, round_idx, round_key} !== '0) begin
            bad++;
            $display("FAIL reset: got v=%b b=%b d=%b idx=%0d key=%h want all zero",
                     rk_valid, busy, done, round_idx, round_key);
        end
        rst = 1'b0;
    endtask

    task automatic test_encrypt_known;
        int          kidx [7] = '{0, 1, 2, 4, 5, 14, 15};
        logic [47:0] kval [7] = '{48'h0B02679B49A5, 48'h69A659256A26, 48'h45D48AB428D2,
                                  48'h3CE80317A6C2, 48'h23251E3C8545, 48'hB691050A16B5,
                                  48'hCA3D03B87032};
        compute_keys(KNOWN, 1'b0);
        issue_start(KNOWN, 1'b0);
        collect(0, 0, "enc_known");
        for (int i = 0; i < 7; i++) begin
            total++;
            if (obs[kidx[i]] !== kval[i]) begin
                bad++;
                $display("FAIL enc_vector K%0d: got %h want %h", kidx[i] + 1, obs[kidx[i]], kval[i]);
            end
        end
    endtask

    task automatic test_decrypt_known;
        int          kidx [3] = '{0, 1, 15};
        logic [47:0] kval [3] = '{48'hCA3D03B87032, 48'hB691050A16B5, 48'h0B02679B49A5};
        compute_keys(KNOWN, 1'b1);
        issue_start(KNOWN, 1'b1);
        collect(0, 0, "dec_known");
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs[kidx[i]] !== kval[i]) begin
                bad++;
                $display("FAIL dec_vector pos%0d: got %h want %h", kidx[i], obs[kidx[i]], kval[i]);
            end
        end
    endtask

    task automatic test_stall;
        compute_keys(KNOWN, 1'b0);
        issue_start(KNOWN, 1'b0);
        collect(2, 0, "stall");
        total++;
        if ({obs[4], obs[5]} !== {48'h3CE80317A6C2, 48'h23251E3C8545}) begin
            bad++;
            $display("FAIL stall_keys: got %h %h want 3ce80317a6c2 23251e3c8545", obs[4], obs[5]);
        end
    endtask

    task automatic test_start_ignored_and_chain;
        compute_keys(KNOWN, 1'b0);
        issue_start(KNOWN, 1'b0);
        next_key = {$urandom, $urandom};
        next_dec = 1'($urandom);
        collect(3, 1, "start_ignored");
        compute_keys(next_key, next_dec);
        collect(1, 0, "chained_start");
    endtask

    task automatic test_async_reset;
        compute_keys(KNOWN, 1'b0);
        issue_start(KNOWN, 1'b0);
        collect(4, 0, "async_rst");
        issue_start(KNOWN, 1'b0);
        collect(0, 0, "post_rst");
    endtask

    task automatic test_random;
        logic [63:0] k;
        logic        dec;
        for (int n = 0; n < 5; n++) begin
            k   = {$urandom, $urandom};
            dec = 1'($urandom);
            compute_keys(k, dec);
            issue_start(k, dec);
            collect(1, 0, "random");
        end
    endtask

    task automatic test_parity;
        logic [63:0] k;
        k = {$urandom, $urandom};
        compute_keys(k, 1'b0);
        issue_start(k ^ 64'h0101010101010101, 1'b0);
        collect(1, 0, "parity");
    endtask

`ifdef DES_KS_ABORT_EN
    task automatic test_abort;
        compute_keys(KNOWN, 1'b0);
        issue_start(KNOWN, 1'b0);
        collect(5, 0, "abort");
        @(posedge clk);
        #1;
        issue_start(KNOWN, 1'b0);
        collect(0, 0, "post_abort");
    endtask
`endif

    initial begin
        test_reset();
        test_encrypt_known();
        test_decrypt_known();
        test_stall();
        test_start_ignored_and_chain();
        test_async_reset();
        test_random();
        test_parity();
`ifdef DES_KS_ABORT_EN
        test_abort();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
